// File: rtl/display_scan_ctrl_pkg.sv
// Shared code constants, 7-segment patterns and the code-to-segment lookup
// for the multiplexed display path.
package display_pkg;

    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_P     = 4'hB;
    localparam logic [3:0] CODE_E     = 4'hC;
    localparam logic [3:0] CODE_F     = 4'hD;
    localparam logic [3:0] CODE_L     = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    // Active-high patterns ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_P     = 7'h73;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_L     = 7'h38;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] code_to_seg(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'h0:       seg = SEG_0;
            4'h1:       seg = SEG_1;
            4'h2:       seg = SEG_2;
            4'h3:       seg = SEG_3;
            4'h4:       seg = SEG_4;
            4'h5:       seg = SEG_5;
            4'h6:       seg = SEG_6;
            4'h7:       seg = SEG_7;
            4'h8:       seg = SEG_8;
            4'h9:       seg = SEG_9;
            CODE_DASH:  seg = SEG_DASH;
            CODE_P:     seg = SEG_P;
            CODE_E:     seg = SEG_E;
            CODE_F:     seg = SEG_F;
            CODE_L:     seg = SEG_L;
            default:    seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_seg_decoder.sv
// Combinational digit decoder: code + dp + dark -> active-high {dp,g,f,e,d,c,b,a}.
// Zero latency; output polarity is left to the parent.
module seg_decoder
    import display_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dp,
    input  logic       dark,
    output logic [7:0] seg
);

    always_comb begin
        seg = 8'h00;
        if (!dark) begin
            seg = {dp, code_to_seg(code)};
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scanner with per-frame input snapshot, blank, blink and dp.
// Optional DISPLAY_SCAN_DIM_EN adds a Brightness input that shortens the anode duty per slot.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int DIV_MAX          = 104165,
    parameter int BLINK_FRAMES     = 64,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [4*NUM_DIGITS-1:0] Codes,
    input  logic [NUM_DIGITS-1:0]   DpMask,
    input  logic [NUM_DIGITS-1:0]   BlankMask,
    input  logic [NUM_DIGITS-1:0]   BlinkMask,
`ifdef DISPLAY_SCAN_DIM_EN
    input  logic [2:0]              Brightness,
`endif
    output logic [NUM_DIGITS-1:0]   Anodes,
    output logic [7:0]              Cathodes,
    output logic                    FrameStart
);

    localparam int PW = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0]           prescaler_q, prescaler_d;
    logic [IW-1:0]           index_q, index_d;
    logic [4*NUM_DIGITS-1:0] sh_codes_q, sh_codes_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
    logic [NUM_DIGITS-1:0]   sh_blink_q, sh_blink_d;
    logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
    logic                    phase_off_q, phase_off_d;
    logic                    running_q, running_d;
    logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
    logic [7:0]              cathodes_q, cathodes_d;
    logic                    frame_start_q, frame_start_d;
`ifdef DISPLAY_SCAN_DIM_EN
    logic [2:0]              sh_bright_q, sh_bright_d;
    logic [31:0]             dim_thresh;
`endif

    logic                    tick, wrap, dark, anode_on;
    logic [3:0]              code_sel;
    logic [7:0]              seg_act;
    logic [NUM_DIGITS-1:0]   anode_act;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prescaler_q   <= '0;
            index_q       <= IW'(NUM_DIGITS - 1);
            sh_codes_q    <= {NUM_DIGITS{CODE_BLANK}};
            sh_dp_q       <= '0;
            sh_blank_q    <= '1;
            sh_blink_q    <= '0;
            blink_cnt_q   <= '0;
            phase_off_q   <= 1'b0;
            running_q     <= 1'b0;
            anodes_q      <= ANODE_ACTIVE_LOW ? '1 : '0;
            cathodes_q    <= SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
            frame_start_q <= 1'b0;
`ifdef DISPLAY_SCAN_DIM_EN
            sh_bright_q   <= 3'd7;
`endif
        end else begin
            prescaler_q   <= prescaler_d;
            index_q       <= index_d;
            sh_codes_q    <= sh_codes_d;
            sh_dp_q       <= sh_dp_d;
            sh_blank_q    <= sh_blank_d;
            sh_blink_q    <= sh_blink_d;
            blink_cnt_q   <= blink_cnt_d;
            phase_off_q   <= phase_off_d;
            running_q     <= running_d;
            anodes_q      <= anodes_d;
            cathodes_q    <= cathodes_d;
            frame_start_q <= frame_start_d;
`ifdef DISPLAY_SCAN_DIM_EN
            sh_bright_q   <= sh_bright_d;
`endif
        end
    end

    // Scan timing, snapshot and blink state all advance together on the frame wrap.
    always_comb begin
        tick          = (prescaler_q == PW'(DIV_MAX));
        wrap          = tick && (index_q == IW'(NUM_DIGITS - 1));
        prescaler_d   = tick ? '0 : prescaler_q + PW'(1);
        index_d       = index_q;
        sh_codes_d    = sh_codes_q;
        sh_dp_d       = sh_dp_q;
        sh_blank_d    = sh_blank_q;
        sh_blink_d    = sh_blink_q;
        blink_cnt_d   = blink_cnt_q;
        phase_off_d   = phase_off_q;
        running_d     = running_q | wrap;
        frame_start_d = wrap;
`ifdef DISPLAY_SCAN_DIM_EN
        sh_bright_d   = sh_bright_q;
`endif
        if (tick) begin
            index_d = wrap ? '0 : index_q + IW'(1);
        end
        if (wrap) begin
            sh_codes_d = Codes;
            sh_dp_d    = DpMask;
            sh_blank_d = BlankMask;
            sh_blink_d = BlinkMask;
`ifdef DISPLAY_SCAN_DIM_EN
            sh_bright_d = Brightness;
`endif
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                phase_off_d = ~phase_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    // Outputs are computed from next-state values so they switch on the tick edge itself.
    always_comb begin
        code_sel = sh_codes_d[4*int'(index_d) +: 4];
        dark     = sh_blank_d[index_d] | (sh_blink_d[index_d] & phase_off_d);
        anode_on = running_d;
`ifdef DISPLAY_SCAN_DIM_EN
        dim_thresh = (32'(DIV_MAX + 1) * (32'(sh_bright_d) + 32'd1)) >> 3;
        anode_on   = running_d && (32'(prescaler_d) < dim_thresh);
`endif
        anode_act  = anode_on ? ({{(NUM_DIGITS-1){1'b0}}, 1'b1} << index_d) : '0;
        anodes_d   = ANODE_ACTIVE_LOW ? ~anode_act : anode_act;
        cathodes_d = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
    end

    seg_decoder u_seg_decoder (
        .code (code_sel),
        .dp   (sh_dp_d[index_d]),
        .dark (dark),
        .seg  (seg_act)
    );

    assign Anodes     = anodes_q;
    assign Cathodes   = cathodes_q;
    assign FrameStart = frame_start_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: reference model derives expected outputs from the
// clock count since reset release and the inputs captured at each frame start.
module tb_display_scan_ctrl;

    localparam int N     = 4;
    localparam int DIV   = 3;
    localparam int BF    = 2;
    localparam int D1    = DIV + 1;
    localparam int FRAME = N * D1;

    logic          Clk, Reset;
    logic [4*N-1:0] Codes;
    logic [N-1:0]  DpMask, BlankMask, BlinkMask;
    logic [N-1:0]  Anodes;
    logic [7:0]    Cathodes;
    logic          FrameStart;
`ifdef DISPLAY_SCAN_DIM_EN
    logic [2:0]    Brightness;
    logic [2:0]    snap_bright;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [4*N-1:0] snap_codes;
    logic [N-1:0]   snap_dp, snap_blank, snap_blink;

    // Glyphs, active-high {g,f,e,d,c,b,a}: 0-9, '-', P, E, F, L, blank
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h73, 7'h79, 7'h71, 7'h38, 7'h00};

    display_scan_ctrl #(
        .NUM_DIGITS(N), .DIV_MAX(DIV), .BLINK_FRAMES(BF),
        .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Codes      (Codes),
        .DpMask     (DpMask),
        .BlankMask  (BlankMask),
        .BlinkMask  (BlinkMask),
`ifdef DISPLAY_SCAN_DIM_EN
        .Brightness (Brightness),
`endif
        .Anodes     (Anodes),
        .Cathodes   (Cathodes),
        .FrameStart (FrameStart)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic bit is_frame_start();
        return (cyc >= D1) && ((cyc - D1) % FRAME == 0);
    endfunction

    function automatic logic [N-1:0] exp_anodes();
        int m, d;
        logic [N-1:0] a;
        if (cyc < D1) return '1;
        m = cyc / D1;
        d = (m - 1) % N;
        a = '1;
        a[d] = 1'b0;
`ifdef DISPLAY_SCAN_DIM_EN
        if ((cyc % D1) >= ((D1 * (int'(snap_bright) + 1)) >> 3)) a = '1;
`endif
        return a;
    endfunction

    function automatic logic [7:0] exp_cathodes();
        int m, d, frame;
        bit off, dark;
        logic [3:0] code;
        logic [7:0] seg;
        if (cyc < D1) return 8'hFF;
        m     = cyc / D1;
        d     = (m - 1) % N;
        frame = (m - 1) / N + 1;
        off   = ((frame / BF) % 2) == 1;
        dark  = snap_blank[d] || (snap_blink[d] && off);
        code  = snap_codes[4*d +: 4];
        seg   = dark ? 8'h00 : {snap_dp[d], glyph[code]};
        return ~seg;
    endfunction

    // One clock: capture model snapshot on frame-start edges, return at the falling edge.
    task automatic step();
        @(posedge Clk);
        cyc++;
        if (is_frame_start()) begin
            snap_codes = Codes;
            snap_dp    = DpMask;
            snap_blank = BlankMask;
            snap_blink = BlinkMask;
`ifdef DISPLAY_SCAN_DIM_EN
            snap_bright = Brightness;
`endif
        end
        @(negedge Clk);
    endtask

    task automatic wait_frame_start();
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (is_frame_start()) break;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge Clk);
        checks++; if (Anodes !== 4'hF) begin errors++; $display("FAIL reset_anodes got=%b exp=1111", Anodes); end
        checks++; if (Cathodes !== 8'hFF) begin errors++; $display("FAIL reset_cathodes got=%h exp=ff", Cathodes); end
        checks++; if (FrameStart !== 1'b0) begin errors++; $display("FAIL reset_fs got=%b exp=0", FrameStart); end
        Reset = 1'b0;
        cyc   = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i < 4) begin
                checks++; if (Anodes !== 4'hF || Cathodes !== 8'hFF || FrameStart !== 1'b0) begin
                    errors++; $display("FAIL pre_frame clk=%0d got an=%b cat=%h fs=%b exp an=1111 cat=ff fs=0", i, Anodes, Cathodes, FrameStart);
                end
            end else if (i == 4) begin
                checks++; if (FrameStart !== 1'b1) begin errors++; $display("FAIL first_fs got=%b exp=1", FrameStart); end
                checks++; if (Anodes !== 4'b1110) begin errors++; $display("FAIL first_anodes got=%b exp=1110", Anodes); end
                checks++; if (Cathodes !== 8'hC0) begin errors++; $display("FAIL first_digit got=%h exp=c0", Cathodes); end
            end else if (i == 8) begin
                checks++; if (Anodes !== 4'b1101) begin errors++; $display("FAIL digit1_anodes got=%b exp=1101", Anodes); end
                checks++; if (Cathodes !== 8'hF9) begin errors++; $display("FAIL digit1_cat got=%h exp=f9", Cathodes); end
                checks++; if (FrameStart !== 1'b0) begin errors++; $display("FAIL digit1_fs got=%b exp=0", FrameStart); end
            end
        end
    endtask

    task automatic test_digits();
        logic [7:0] pat [N] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
        Codes = 16'h3210; DpMask = '0; BlankMask = '0; BlinkMask = '0;
        wait_frame_start();
        checks++; if (FrameStart !== 1'b1) begin errors++; $display("FAIL digits_fs got=%b exp=1", FrameStart); end
        for (int i = 0; i < FRAME; i++) begin
            if (i % D1 == 0) begin
                checks++; if (Cathodes !== pat[i / D1]) begin
                    errors++; $display("FAIL digits_pattern slot=%0d got=%h exp=%h", i / D1, Cathodes, pat[i / D1]);
                end
            end
            checks++; if (Anodes !== exp_anodes()) begin errors++; $display("FAIL digits_anodes cyc=%0d got=%b exp=%b", cyc, Anodes, exp_anodes()); end
            step();
        end
    endtask

    task automatic test_midframe();
        Codes = 16'h3210;
        wait_frame_start();
        repeat (2 * D1 + 1) step();
        Codes = 16'h9876;
        for (int i = 2 * D1 + 1; i < FRAME + D1; i++) begin
            if (i == 3 * D1) begin
                checks++; if (Cathodes !== 8'hB0) begin errors++; $display("FAIL mid_old_digit3 got=%h exp=b0", Cathodes); end
            end
            checks++; if (Cathodes !== exp_cathodes()) begin errors++; $display("FAIL mid_cathodes cyc=%0d got=%h exp=%h", cyc, Cathodes, exp_cathodes()); end
            checks++; if (FrameStart !== is_frame_start()) begin errors++; $display("FAIL mid_fs cyc=%0d got=%b exp=%b", cyc, FrameStart, is_frame_start()); end
            if (i == FRAME) begin
                checks++; if (Cathodes !== 8'h82) begin errors++; $display("FAIL mid_new_digit0 got=%h exp=82", Cathodes); end
            end
            step();
        end
    endtask

    task automatic test_blink();
        int lit = 0;
        Codes = 16'h3210; BlinkMask = 4'b0001;
        wait_frame_start();
        for (int i = 0; i < 8 * FRAME; i++) begin
            if (i % FRAME == 0 && Cathodes !== 8'hFF) lit++;
            checks++; if (Cathodes !== exp_cathodes()) begin errors++; $display("FAIL blink_cathodes cyc=%0d got=%h exp=%h", cyc, Cathodes, exp_cathodes()); end
            checks++; if (Anodes !== exp_anodes()) begin errors++; $display("FAIL blink_anodes cyc=%0d got=%b exp=%b", cyc, Anodes, exp_anodes()); end
            step();
        end
        checks++; if (lit !== 4) begin errors++; $display("FAIL blink_lit_frames got=%0d exp=4", lit); end
        BlinkMask = '0;
    endtask

    task automatic test_blank_dp();
        Codes = 16'h3210; BlankMask = 4'b1000; DpMask = 4'b0100;
        wait_frame_start();
        for (int i = 0; i < FRAME; i++) begin
            if (i == 2 * D1) begin
                checks++; if (Cathodes !== 8'h24) begin errors++; $display("FAIL dp_digit2 got=%h exp=24", Cathodes); end
            end
            if (i == 3 * D1) begin
                checks++; if (Cathodes !== 8'hFF) begin errors++; $display("FAIL blank_digit3 got=%h exp=ff", Cathodes); end
                checks++; if (Anodes !== 4'b0111) begin errors++; $display("FAIL blank_anode3 got=%b exp=0111", Anodes); end
            end
            checks++; if (Cathodes !== exp_cathodes()) begin errors++; $display("FAIL blankdp_cathodes cyc=%0d got=%h exp=%h", cyc, Cathodes, exp_cathodes()); end
            step();
        end
        BlankMask = '0; DpMask = '0;
    endtask

    task automatic test_reset_midframe();
        wait_frame_start();
        repeat (6) step();
        #2 Reset = 1'b1;
        #1;
        checks++; if (Anodes !== 4'hF || Cathodes !== 8'hFF || FrameStart !== 1'b0) begin
            errors++; $display("FAIL async_reset got an=%b cat=%h fs=%b exp an=1111 cat=ff fs=0", Anodes, Cathodes, FrameStart);
        end
        @(negedge Clk);
        Reset = 1'b0;
        cyc   = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            checks++; if (Anodes !== exp_anodes()) begin errors++; $display("FAIL rst_anodes cyc=%0d got=%b exp=%b", cyc, Anodes, exp_anodes()); end
            checks++; if (Cathodes !== exp_cathodes()) begin errors++; $display("FAIL rst_cathodes cyc=%0d got=%h exp=%h", cyc, Cathodes, exp_cathodes()); end
            checks++; if (FrameStart !== is_frame_start()) begin errors++; $display("FAIL rst_fs cyc=%0d got=%b exp=%b", cyc, FrameStart, is_frame_start()); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30 * FRAME; i++) begin
            if ($urandom_range(9) == 0) begin
                Codes     = 16'($urandom);
                DpMask    = 4'($urandom);
                BlankMask = 4'($urandom_range(3) == 0 ? $urandom : 0);
                BlinkMask = 4'($urandom);
`ifdef DISPLAY_SCAN_DIM_EN
                Brightness = 3'($urandom);
`endif
            end
            step();
            checks++; if (Anodes !== exp_anodes()) begin errors++; $display("FAIL rand_anodes cyc=%0d got=%b exp=%b", cyc, Anodes, exp_anodes()); end
            checks++; if (Cathodes !== exp_cathodes()) begin errors++; $display("FAIL rand_cathodes cyc=%0d got=%h exp=%h", cyc, Cathodes, exp_cathodes()); end
            checks++; if (FrameStart !== is_frame_start()) begin errors++; $display("FAIL rand_fs cyc=%0d got=%b exp=%b", cyc, FrameStart, is_frame_start()); end
        end
    endtask

`ifdef DISPLAY_SCAN_DIM_EN
    task automatic test_dim();
        int on_cnt;
        logic [2:0] lvl [2] = '{3'd1, 3'd7};
        int expn [2] = '{1, 4};
        BlankMask = '0; BlinkMask = '0;
        for (int k = 0; k < 2; k++) begin
            Brightness = lvl[k];
            wait_frame_start();
            on_cnt = 0;
            for (int i = 0; i < D1; i++) begin
                if (Anodes[0] === 1'b0) on_cnt++;
                step();
            end
            checks++; if (on_cnt !== expn[k]) begin
                errors++; $display("FAIL dim_duty bright=%0d got=%0d exp=%0d", lvl[k], on_cnt, expn[k]);
            end
        end
    endtask
`endif

    initial begin
        Reset = 1'b1; Codes = 16'h3210; DpMask = '0; BlankMask = '0; BlinkMask = '0;
        snap_codes = '1; snap_dp = '0; snap_blank = '1; snap_blink = '0;
`ifdef DISPLAY_SCAN_DIM_EN
        Brightness = 3'd7; snap_bright = 3'd7;
`endif
        test_reset();
        test_digits();
        test_midframe();
        test_blink();
        test_blank_dp();
        test_reset_midframe();
        test_random();
`ifdef DISPLAY_SCAN_DIM_EN
        test_dim();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Parametrised multiplexed 7-segment driver, the successor of the fixed 4-digit display path. It scans NUM_DIGITS digits from a flat code bus, with per-digit decimal point, blanking and blink. Inputs are snapshotted once per frame so a digit never changes mid-frame. It sits between the parking-status logic and the board's anode/cathode pins.

Parameters:
NUM_DIGITS, 4, digits scanned (2..8)
DIV_MAX, 104165, refresh prescaler terminal count; one digit slot = DIV_MAX+1 clocks
BLINK_FRAMES, 64, frames per blink half-period (>=1)
ANODE_ACTIVE_LOW, 1, 1 = anode enable driven 0
SEG_ACTIVE_LOW, 1, 1 = lit segment driven 0

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-high reset
Codes  input  4*NUM_DIGITS  digit codes; digit i = Codes[4i+3:4i], digit 0 rightmost
DpMask  input  NUM_DIGITS  1 = decimal point lit for digit i
BlankMask  input  NUM_DIGITS  1 = digit i forced dark
BlinkMask  input  NUM_DIGITS  1 = digit i dark during blink-off phase
Anodes  output  NUM_DIGITS  registered one-hot digit enable (polarity per ANODE_ACTIVE_LOW)
Cathodes  output  8  registered segments {dp,g,f,e,d,c,b,a} (polarity per SEG_ACTIVE_LOW)
FrameStart  output  1  one-clock pulse when digit 0 slot begins

Behaviour:
- Reset, asynchronous: prescaler=0; scan index=NUM_DIGITS-1; shadow regs = blank; blink counter=0; blink phase=on; running=0; Anodes all inactive; Cathodes all inactive; FrameStart=0.
- Prescaler counts 0..DIV_MAX and wraps. Tick = prescaler==DIV_MAX.
- On tick, index advances. NUM_DIGITS-1 wraps to 0.
- On a wrap to 0, on the same edge: snapshot Codes/DpMask/BlankMask/BlinkMask into shadow; set running=1; FrameStart=1 for that cycle only.
- Blink: at each frame wrap, blink counter increments. When it reaches BLINK_FRAMES-1 it clears and blink phase toggles. Snapshot and blink update on the same edge use the new phase.
- Outputs are registered from the next index and shadow values, so Anodes/Cathodes change on the tick edge, 1 clock after the prescaler reaches DIV_MAX. No intermediate digit is ever shown.
- Anodes: running=0 gives all inactive; otherwise only bit[index] is active.
- Segment code map: 0x0-0x9 decimal digits, 0xA '-', 0xB 'P', 0xC 'E', 0xD 'F', 0xE 'L', 0xF blank.
- Digit is dark (segments and dp off, anode still scanned) if BlankMask[i], or if BlinkMask[i] and phase=off.
- Input changes mid-frame have no visible effect until the next frame start.
- Reset mid-frame: outputs go inactive immediately. The first frame after release starts DIV_MAX+1 clocks later.
- Frame period = NUM_DIGITS*(DIV_MAX+1) clocks, exact, no drift.

Optional Feature:
DISPLAY_SCAN_DIM_EN.
- Defined: extra input Brightness[2:0], snapshotted with the other inputs. The anode is active only while prescaler < ((DIV_MAX+1)*(Brightness+1))>>3, evaluated per cycle and registered. Brightness=7 gives full duty. Cathodes are unaffected.
- Undefined: no Brightness port; anode active for the whole slot.

Decomposition:
- Package display_pkg holds:
  - code constants (CODE_DASH=4'hA, CODE_P, CODE_E, CODE_F, CODE_L, CODE_BLANK=4'hF)
  - 7-bit segment pattern constants
  - the code-to-segment function.
- Sub-module seg_decoder: 4-bit code + dp + dark -> 8-bit active-high segments. Polarity is applied in the parent.

Test Plan:
- Reset release, DIV_MAX=3, NUM_DIGITS=4 -> outputs inactive for 4 clocks; FrameStart on clock 4; Anodes=4'b1110, digit 0 shown; digit 1 at clock 8.
- Codes=16'h3210, all masks 0 -> across one frame Cathodes cycle through patterns '0','1','2','3' (active-low 0xC0, 0xF9, 0xA4, 0xB0) in slot order.
- Codes changed in the middle of the digit 2 slot -> digit 3 still shows the old value; the new value first appears after the next FrameStart.
- BlinkMask=4'b0001, BLINK_FRAMES=2 -> digit 0 lit 2 frames, dark 2 frames, repeating; other digits always lit.
- BlankMask=4'b1000, DpMask=4'b0100 -> digit 3 all segments off while its anode is still scanned; digit 2 dp bit active.
- With DISPLAY_SCAN_DIM_EN, DIV_MAX=7, Brightness=1 -> anode active 2 of 8 clocks per slot; Brightness=7 -> 8 of 8.
